// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Latches rising edges on N event lines into pending flags and serves them
// one at a time to a shared consumer over valid/ready, round-robin order.
// A lost edge (re-edge while already pending and not being granted) sets a
// sticky per-line overflow bit.

module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overflow,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [0:0]       state;
    logic [N-1:0]     in_q;
    logic [N-1:0]     prev;
    logic [N-1:0]     edge_det;
    logic [N-1:0]     grant;
    logic             handshake;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [N-1:0]     pick_vec;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // evt_valid is a direct decode of the state flop, so it stays registered
    assign evt_valid = (state == S_OFFER);
    assign handshake = evt_valid & evt_ready;
    assign edge_det  = in_q & ~prev;

    // one-hot grant of the offered line on a handshake
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = handshake && (evt_idx == IDX_W'(i));
        end
    end

    // pointer just past the offered line, wrapping at N-1
    assign next_ptr = (evt_idx >= IDX_W'(N - 1)) ? '0 : evt_idx + IDX_W'(1);

    // idle searches all pending lines from ptr; on a handshake the granted
    // line is masked (a re-edge of it waits for its turn) and search starts
    // just past it
    assign pick_vec   = (state == S_OFFER) ? (pending & ~grant) : pending;
    assign pick_start = (state == S_OFFER) ? next_ptr : ptr;

    // round-robin pick: first set bit at or after pick_start, with wrap
    always_comb begin
        int k;
        k          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int j = 0; j < N; j++) begin
            k = int'(pick_start) + j;
            if (k >= N) k = k - N;
            if (!pick_found && pick_vec[k]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(k);
            end
        end
    end

    // input sampling; in_q just follows the line, so a line held high through
    // reset sees prev=1 afterwards and produces no edge
    always_ff @(posedge clk) begin
        in_q <= in;
    end

    // edge history, pending and sticky overflow flags
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '1;
            pending  <= '0;
            overflow <= '0;
        end else begin
            prev     <= in_q;
            pending  <= edge_det | (pending & ~grant);
            overflow <= (overflow & {N{~ovf_clr}}) | (edge_det & pending & ~grant);
        end
    end

    // arbiter FSM: offer one index at a time, chain directly on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            evt_idx <= '0;
            ptr     <= '0;
            evt_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (pick_found) begin
                evt_idx <= pick_idx;
                state   <= S_OFFER;
            end
        end else begin
            if (evt_ready) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
                ptr     <= next_ptr;
                if (pick_found) evt_idx <= pick_idx;
                else            state   <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed scenarios with constant
// expectations plus a randomized run checked against a behavioural model.

module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic [N-1:0]     pending;
    logic [N-1:0]     overflow;
    logic             ovf_clr;
    logic [CNT_W-1:0] evt_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit [N-1:0] m_h1, m_h2, m_pend, m_ovf;
    bit         m_valid;
    int         m_idx, m_ptr, m_cnt;

    edge_event_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
        .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input bit [N-1:0] v, input int start);
        for (int j = 0; j < N; j++) begin
            if (v[(start + j) % N]) return (start + j) % N;
        end
        return -1;
    endfunction

    // one clock: advance the model from pre-edge inputs, then settle past the edge
    task automatic tick();
        bit [N-1:0] e, g, np, no, nh1, nh2;
        bit nv;
        int ni, nptr, ncnt, f;
        nh1 = in;
        if (rst) begin
            nh2 = '1; np = '0; no = '0; nv = 0; ni = 0; nptr = 0; ncnt = 0;
        end else begin
            nh2 = m_h1;
            e = m_h1 & ~m_h2;
            g = '0;
            if (m_valid && evt_ready) g[m_idx] = 1'b1;
            np = e | (m_pend & ~g);
            no = (ovf_clr ? '0 : m_ovf) | (e & m_pend & ~g);
            nv = m_valid; ni = m_idx; nptr = m_ptr; ncnt = m_cnt;
            if (!m_valid) begin
                f = first_from(m_pend, m_ptr);
                if (f >= 0) begin nv = 1; ni = f; end
            end else if (evt_ready) begin
                ncnt = (m_cnt + 1) % (1 << CNT_W);
                nptr = (m_idx + 1) % N;
                f = first_from(m_pend & ~g, nptr);
                if (f >= 0) ni = f;
                else        nv = 0;
            end
        end
        @(posedge clk);
        #1;
        m_h1 = nh1; m_h2 = nh2; m_pend = np; m_ovf = no;
        m_valid = nv; m_idx = ni; m_ptr = nptr; m_cnt = ncnt;
    endtask

    task automatic do_reset(input logic [N-1:0] lvl);
        rst = 1'b1; in = lvl; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int hs;
        logic [IDX_W-1:0] last_idx;
        rst = 1'b1; in = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({evt_valid, evt_idx, pending, overflow, evt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b idx=%0d pend=%b ovf=%b cnt=%0d want all zero",
                     evt_valid, evt_idx, pending, overflow, evt_cnt);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL held_high_no_event: got pend=%b v=%0b want 0000/0", pending, evt_valid);
            end
        end
        in = 4'b1011; tick();
        in = 4'b1111; evt_ready = 1'b1;
        hs = 0; last_idx = '0;
        for (int c = 0; c < 8; c++) begin
            if (evt_valid && evt_ready) begin hs++; last_idx = evt_idx; end
            tick();
        end
        checks++;
        if (hs != 1 || last_idx !== 2'd2 || evt_cnt !== 4'd1) begin
            errors++;
            $display("FAIL reedge_line2: got offers=%0d idx=%0d cnt=%0d want 1/2/1", hs, last_idx, evt_cnt);
        end
    endtask

    task automatic test_latency();
        do_reset(4'b0000);
        evt_ready = 1'b1;
        in = 4'b0001; tick();
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL lat_k: got pend=%b want 0000", pending);
        end
        tick();
        checks++;
        if (pending !== 4'b0001 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL lat_k1: got pend=%b v=%0b want 0001/0", pending, evt_valid);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd0) begin
            errors++; $display("FAIL lat_k2: got v=%0b idx=%0d want 1/0", evt_valid, evt_idx);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000 || evt_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lat_k3: got v=%0b pend=%b cnt=%0d want 0/0000/1", evt_valid, pending, evt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int exp_idx [3] = '{0, 1, 3};
        do_reset(4'b0000);
        evt_ready = 1'b1;
        in = 4'b1011; tick(); tick();
        checks++;
        if (pending !== 4'b1011) begin
            errors++; $display("FAIL b2b_pending: got %b want 1011", pending);
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_idx !== IDX_W'(exp_idx[s])) begin
                errors++;
                $display("FAIL b2b_offer%0d: got v=%0b idx=%0d want 1/%0d", s, evt_valid, evt_idx, exp_idx[s]);
            end
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || evt_cnt !== 4'd3) begin
            errors++; $display("FAIL b2b_done: got v=%0b cnt=%0d want 0/3", evt_valid, evt_cnt);
        end
    endtask

    task automatic test_stall_overflow();
        do_reset(4'b0000);
        in = 4'b0010; tick(); tick(); tick();
        for (int c = 0; c < 5; c++) begin
            in[1] = (c == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
                errors++; $display("FAIL stall_hold%0d: got v=%0b idx=%0d want 1/1", c, evt_valid, evt_idx);
            end
        end
        checks++;
        if (overflow !== 4'b0010 || pending !== 4'b0010) begin
            errors++; $display("FAIL stall_ovf: got ovf=%b pend=%b want 0010/0010", overflow, pending);
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++; $display("FAIL ovf_clr: got %b want 0000", overflow);
        end
        evt_ready = 1'b1; tick();
        checks++;
        if (evt_valid !== 1'b0 || evt_cnt !== 4'd1) begin
            errors++; $display("FAIL stall_release: got v=%0b cnt=%0d want 0/1", evt_valid, evt_cnt);
        end
    endtask

    task automatic test_wrap_order();
        do_reset(4'b0000);
        evt_ready = 1'b1;
        in = 4'b0010; tick();
        in = 4'b0000; tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
            errors++; $display("FAIL wrap_first: got v=%0b idx=%0d want 1/1", evt_valid, evt_idx);
        end
        tick();
        evt_ready = 1'b0;
        in = 4'b0011; tick(); tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd0) begin
            errors++; $display("FAIL wrap_line0: got v=%0b idx=%0d want 1/0", evt_valid, evt_idx);
        end
        evt_ready = 1'b1; tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
            errors++; $display("FAIL wrap_line1: got v=%0b idx=%0d want 1/1", evt_valid, evt_idx);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || evt_cnt !== 4'd3) begin
            errors++; $display("FAIL wrap_done: got v=%0b cnt=%0d want 0/3", evt_valid, evt_cnt);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset(4'b0000);
        evt_ready = 1'b1;
        in = 4'b0010; tick();
        in = 4'b0000; tick(); tick(); tick();
        evt_ready = 1'b0;
        in = 4'b1000; tick(); tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd3) begin
            errors++; $display("FAIL mid_pre: got v=%0b idx=%0d want 1/3", evt_valid, evt_idx);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({evt_valid, evt_idx, pending, overflow, evt_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b idx=%0d pend=%b ovf=%b cnt=%0d want all zero",
                     evt_valid, evt_idx, pending, overflow, evt_cnt);
        end
        in = 4'b0000; tick();
        in = 4'b1010; tick(); tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
            errors++; $display("FAIL mid_ptr0: got v=%0b idx=%0d want 1/1", evt_valid, evt_idx);
        end
    endtask

    task automatic test_random();
        do_reset(4'b0000);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(2) == 0) in[i] = ~in[i];
            end
            evt_ready = ($urandom_range(2) != 0);
            ovf_clr   = ($urandom_range(15) == 0);
            rst       = ($urandom_range(199) == 0);
            tick();
            checks++;
            if ({evt_valid, evt_idx, pending, overflow, evt_cnt} !==
                {m_valid, IDX_W'(m_idx), m_pend, m_ovf, CNT_W'(m_cnt)}) begin
                errors++;
                $display("FAIL rand_cyc%0d: got v=%0b idx=%0d pend=%b ovf=%b cnt=%0d want v=%0b idx=%0d pend=%b ovf=%b cnt=%0d",
                         c, evt_valid, evt_idx, pending, overflow, evt_cnt,
                         m_valid, m_idx, m_pend, m_ovf, m_cnt);
            end
        end
        rst = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall_overflow();
        test_wrap_order();
        test_reset_mid_offer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Detects rising edges on N asynchronous-to-consumer event lines and latches one pending flag per line.
- Serves pending events one at a time to a single shared consumer over a valid/ready channel, using round-robin priority.
- Sits between the raw edge-detector inputs and a shared event handler. Replaces per-line handlers with one sequenced stream.

Parameters:
- N, 4, number of event lines (1..16)
- IDX_W, $clog2(N) (min 1), width of the event index
- CNT_W, 8, width of the delivered-event counter

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous and active-high.
- in  in  N  raw event lines, already synchronous to clk
- evt_valid  out  1  an event is offered to the consumer
- evt_ready  in  1  consumer accepts the offered event
- evt_idx  out  IDX_W  index of the offered line. Stable while evt_valid=1.
- pending  out  N  per-line pending flags
- overflow  out  N  sticky flag per line: an edge was lost
- ovf_clr  in  1  single-cycle pulse that clears all overflow bits
- evt_cnt  out  CNT_W  count of accepted events, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous, taken on the rising clk edge with rst=1. It overrides all other inputs and clears everything, including any in-flight offer:
  - evt_valid=0, evt_idx=0, pending=0, overflow=0, evt_cnt=0
  - round-robin pointer ptr=0, FSM state=IDLE
  - prev=all ones, so a line held high through reset generates no event until it has gone low and then high again.
- Edge detection, per line i:
  - Registers: in_q[i] <= in[i]; prev[i] <= in_q[i].
  - edge[i] = in_q[i] & ~prev[i].
  - If in[i] is first high at clk edge k (low at edge k-1), pending[i] reads 1 after edge k+1.
  - A line held high produces exactly one edge.
- Pending and overflow update at each edge, where grant_i = evt_valid & evt_ready & (evt_idx==i):
  - If edge[i]=1, pending[i] is set.
  - Else if grant_i=1, pending[i] is cleared.
  - Else pending[i] holds.
  - Edge and grant in the same cycle: pending stays 1, a new event; no overflow.
  - Edge while pending[i]=1 and grant_i=0: overflow[i] is set and the edge is merged into the existing pending.
  - ovf_clr clears all overflow bits. If an overflow event coincides with ovf_clr, the set wins.
- Arbiter FSM. States are IDLE and OFFER; outputs are registered (Moore style).
  - IDLE: evt_valid=0. If any pending bit is 1, select the first set bit at or after ptr, searching upward with wrap from N-1 to 0. Load it into evt_idx and go to OFFER.
  - OFFER: evt_valid=1 and evt_idx holds while evt_ready=0.
  - On handshake:
    - pending[evt_idx] clears (unless re-edged), evt_cnt increments, ptr = (evt_idx+1) mod N.
    - Selection uses the pending vector with the granted bit masked, starting from the new ptr.
    - If any bit remains, the next index is loaded and the FSM stays in OFFER, giving back-to-back throughput of 1 event/cycle.
    - Otherwise the FSM goes to IDLE.
  - A granted line that re-edged in the handshake cycle is served again only after its turn comes around in rotation.
- Latency: in[i] rising before edge k with the arbiter idle gives evt_valid=1 after edge k+2.
- An edge arriving while evt_valid=1 never changes evt_idx mid-offer.
- N=1: ptr and evt_idx are constant 0. Back-to-back operation applies only if the line re-edged.
- evt_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset with in=4'b1111 held high, then release: no events and pending=0. Drop in[2] for 1 cycle then raise it: exactly one offer with evt_idx=2, and evt_cnt=1 after the handshake.
- in[0]=1 at edge k, evt_ready=1: pending[0]=1 after k+1, evt_valid=1 with evt_idx=0 after k+2, evt_valid=0 after k+3.
- Lines 0, 1 and 3 all rise in the same cycle, evt_ready=1: offers in order 0,1,3 on consecutive cycles, then evt_valid=0 and evt_cnt=3.
- evt_ready=0 for 5 cycles while offering idx 1: evt_idx holds at 1, and a new edge on line 1 sets overflow[1]=1. Then pulse ovf_clr: overflow returns to 0.
- With ptr=2 (line 1 just served) and lines 0 and 1 both pending: line 0 is served before line 1 (wrap order 2,3,0,1).
- Assert rst while evt_valid=1: all outputs read reset values after that edge. Post-reset edges are served from ptr=0.
